// File: rtl/int_seq.sv
// int_seq: fixed-priority interrupt sequencer; define INT_EDGE_EN for edge-latched pending requests
module int_seq #(
  parameter int NREQ = 4,
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] VEC_BASE = 8'hF0
) (
  input  logic            ck,
  input  logic            res,
  input  logic            ck2,
  input  logic [NREQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NREQ-1:0] mask_wdata,
  input  logic            ie_set,
  input  logic            ie_clr,
  input  logic [3:0]      kind,
  input  logic            boundary,
  input  logic [PC_W-1:0] pc,
  input  logic            cc_c,
  input  logic            cc_z,
  output logic            int_c,
  output logic            int_z,
  output logic [PC_W-1:0] int_pc,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] vec,
  output logic [NREQ-1:0] int_ack,
  output logic            in_service,
  output logic            ie,
  output logic [NREQ-1:0] mask
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, SAVE, VECT, SERV} state_t;
  state_t state;
  logic [IW-1:0] idx, win;
  logic [NREQ-1:0] pend, qual;
`ifdef INT_EDGE_EN
  logic [NREQ-1:0] irq_q, clr;
  assign clr = (state == VECT) ? (NREQ'(1) << idx) : '0;
  always_ff @(posedge ck) begin
    if (res) begin
      irq_q <= '0;
      pend <= '0;
    end else if (!ck2) begin
      irq_q <= irq;
      pend <= (pend & ~clr) | (irq & ~irq_q);
    end
  end
`else
  assign pend = irq;
`endif
  assign qual = pend & mask;
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (qual[i]) win = IW'(i);
  end
  always_ff @(posedge ck) begin
    if (res) begin
      state <= IDLE;
      idx <= '0;
      ie <= 1'b0;
      mask <= '0;
      int_c <= 1'b0;
      int_z <= 1'b0;
      int_pc <= '0;
      stall <= 1'b0;
      redirect <= 1'b0;
      vec <= '0;
      int_ack <= '0;
      in_service <= 1'b0;
    end else if (!ck2) begin
      redirect <= 1'b0;
      vec <= '0;
      int_ack <= '0;
      if (mask_we) mask <= mask_wdata;
      case (state)
        IDLE: begin
          ie <= ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie);
          if (ie && |qual && boundary && !ie_clr) begin
            state <= SAVE;
            idx <= win;
            stall <= 1'b1;
          end
        end
        SAVE: begin
          int_c <= cc_c;
          int_z <= cc_z;
          int_pc <= pc;
          ie <= 1'b0;
          state <= VECT;
          redirect <= 1'b1;
          vec <= VEC_BASE + PC_W'(idx);
          int_ack <= NREQ'(1) << idx;
        end
        VECT: begin
          state <= SERV;
          stall <= 1'b0;
          in_service <= 1'b1;
        end
        SERV: if (kind == 4'b1000) begin
          state <= IDLE;
          ie <= 1'b1;
          in_service <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: scoreboard bench for int_seq
module tb_int_seq;
  logic ck = 0, res = 1, ck2 = 0;
  logic [3:0] irq = 0, mask_wdata = 0, kind = 0;
  logic mask_we = 0, ie_set = 0, ie_clr = 0, boundary = 0, cc_c = 0, cc_z = 0;
  logic [7:0] pc = 0;
  logic int_c, int_z, stall, redirect, in_service, ie;
  logic [7:0] int_pc, vec;
  logic [3:0] int_ack, mask;
  typedef struct {logic [7:0] vec; logic [3:0] ack;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  bit got;

  int_seq dut (.ck(ck), .res(res), .ck2(ck2), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ie_set(ie_set), .ie_clr(ie_clr), .kind(kind), .boundary(boundary), .pc(pc), .cc_c(cc_c), .cc_z(cc_z),
    .int_c(int_c), .int_z(int_z), .int_pc(int_pc), .stall(stall), .redirect(redirect), .vec(vec),
    .int_ack(int_ack), .in_service(in_service), .ie(ie), .mask(mask));

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_redirect(output bit seen);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = redirect;
    end
  endtask

  task automatic do_reset();
    res = 1; irq = 0; mask_we = 0; ie_set = 0; ie_clr = 0; kind = 0; boundary = 0; ck2 = 0;
    tick();
    res = 0;
  endtask

  task automatic arm(input logic [3:0] m);
    mask_we = 1; mask_wdata = m; ie_set = 1;
    tick();
    mask_we = 0; ie_set = 0;
  endtask

  task automatic pop_check(input string name);
    e = q.pop_front();
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: redirect=%b required 1", name, redirect);
    end else if ({vec, int_ack} !== {e.vec, e.ack}) begin
      n_fail++;
      $display("FAIL %s_vec: vec=%h ack=%b required vec=%h ack=%b", name, vec, int_ack, e.vec, e.ack);
    end
  endtask

  task automatic test_reset();
    res = 1; ck2 = 1;
    tick(); tick();
    n_chk++;
    if ({ie, mask, int_c, int_z, int_pc, stall, redirect, vec, int_ack, in_service} !== 0) begin
      n_fail++;
      $display("FAIL reset: ie=%b mask=%b pc=%h stall=%b redir=%b vec=%h ack=%b srv=%b required all 0",
        ie, mask, int_pc, stall, redirect, vec, int_ack, in_service);
    end
    res = 0; ck2 = 0;
  endtask

  task automatic test_priority();
    do_reset();
    arm(4'b1111);
    n_chk++;
    if ({ie, mask} !== 5'b11111) begin n_fail++; $display("FAIL arm: ie=%b mask=%b required 1 1111", ie, mask); end
    irq = 4'b0110; boundary = 1; pc = 8'h3A; cc_c = 1; cc_z = 0;
    q.push_back('{8'hF1, 4'b0010});
    tick();
    irq = 0; boundary = 0;
    n_chk++;
    if ({stall, redirect} !== 2'b10) begin n_fail++; $display("FAIL prio_save: stall=%b redir=%b required 1 0", stall, redirect); end
    tick();
    got = redirect;
    pop_check("prio");
    n_chk++;
    if ({stall, int_pc, int_c, int_z, ie} !== {1'b1, 8'h3A, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_saved: stall=%b int_pc=%h c=%b z=%b ie=%b required 1 3a 1 0 0", stall, int_pc, int_c, int_z, ie);
    end
    tick();
    n_chk++;
    if ({stall, redirect, vec, int_ack, in_service} !== {2'b00, 8'h00, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_serv: stall=%b redir=%b vec=%h ack=%b srv=%b required 0 0 00 0000 1",
        stall, redirect, vec, int_ack, in_service);
    end
  endtask

  task automatic test_gating();
    do_reset();
    mask_we = 1; mask_wdata = 4'b1111;
    irq = 4'b0001; boundary = 1;
    tick();
    mask_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({stall, redirect} !== 2'b00) begin n_fail++; $display("FAIL gate_ie: stall=%b redir=%b required 0 0", stall, redirect); end
    end
    mask_we = 1; mask_wdata = 0; ie_set = 1;
    tick();
    mask_we = 0; ie_set = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({stall, redirect} !== 2'b00) begin n_fail++; $display("FAIL gate_mask: stall=%b redir=%b required 0 0", stall, redirect); end
    end
    boundary = 0; mask_we = 1; mask_wdata = 4'b0001;
    tick();
    mask_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({stall, redirect} !== 2'b00) begin n_fail++; $display("FAIL gate_bound: stall=%b redir=%b required 0 0", stall, redirect); end
    end
    boundary = 1; pc = 8'h55; cc_c = 0; cc_z = 1;
    q.push_back('{8'hF0, 4'b0001});
    wait_redirect(got);
    pop_check("gate");
    n_chk++;
    if ({int_pc, int_c, int_z} !== {8'h55, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL gate_saved: int_pc=%h c=%b z=%b required 55 0 1", int_pc, int_c, int_z);
    end
    irq = 0; boundary = 0;
  endtask

  task automatic test_reti();
    do_reset();
    arm(4'b1111);
    irq = 4'b0100; boundary = 1; pc = 8'h77; cc_c = 0; cc_z = 1;
    tick();
    irq = 0; boundary = 0;
    tick(); tick();
    n_chk++;
    if (in_service !== 1'b1) begin n_fail++; $display("FAIL reti_enter: in_service=%b required 1", in_service); end
    cc_c = 1; cc_z = 0; kind = 4'b1000;
    tick();
    kind = 0;
    n_chk++;
    if ({in_service, ie, stall, int_c, int_z, int_pc} !== {3'b010, 1'b0, 1'b1, 8'h77}) begin
      n_fail++;
      $display("FAIL reti_exit: srv=%b ie=%b stall=%b c=%b z=%b pc=%h required 0 1 0 0 1 77",
        in_service, ie, stall, int_c, int_z, int_pc);
    end
    kind = 4'b1000;
    tick();
    kind = 0;
    n_chk++;
    if ({in_service, ie, stall, redirect} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reti_idle: srv=%b ie=%b stall=%b redir=%b required 0 1 0 0", in_service, ie, stall, redirect);
    end
  endtask

  task automatic test_ck2_reset();
    do_reset();
    arm(4'b1111);
    irq = 4'b0001; boundary = 1;
    q.push_back('{8'hF0, 4'b0001});
    tick();
    boundary = 0; irq = 0; ck2 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({stall, redirect, int_ack} !== 6'b100000) begin
        n_fail++;
        $display("FAIL ck2_hold: stall=%b redir=%b ack=%b required 1 0 0000", stall, redirect, int_ack);
      end
    end
    ck2 = 0;
    tick();
    got = redirect;
    pop_check("ck2");
    res = 1; ck2 = 1;
    tick();
    res = 0; ck2 = 0;
    n_chk++;
    if ({ie, mask, int_c, int_z, int_pc, stall, redirect, vec, int_ack, in_service} !== 0) begin
      n_fail++;
      $display("FAIL vect_reset: stall=%b redir=%b vec=%h ack=%b srv=%b mask=%b required all 0",
        stall, redirect, vec, int_ack, in_service, mask);
    end
  endtask

  task automatic test_conflicts();
    do_reset();
    mask_we = 1; mask_wdata = 4'b1111; ie_set = 1; ie_clr = 1;
    tick();
    mask_we = 0; ie_set = 0; ie_clr = 0;
    n_chk++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL set_clr: ie=%b required 0", ie); end
    ie_set = 1;
    tick();
    ie_set = 0;
    irq = 4'b0001; boundary = 1; ie_clr = 1;
    tick();
    ie_clr = 0;
    n_chk++;
    if ({stall, ie} !== 2'b00) begin n_fail++; $display("FAIL clr_block: stall=%b ie=%b required 0 0", stall, ie); end
    ie_set = 1;
    q.push_back('{8'hF0, 4'b0001});
    tick();
    ie_set = 0;
    n_chk++;
    if ({stall, ie} !== 2'b01) begin n_fail++; $display("FAIL set_late: stall=%b ie=%b required 0 1", stall, ie); end
    wait_redirect(got);
    pop_check("conf");
    irq = 0; boundary = 0;
    tick();
    mask_we = 1; mask_wdata = 0; ie_set = 1;
    tick();
    mask_we = 0; ie_set = 0;
    n_chk++;
    if ({mask, in_service, ie} !== 6'b000010) begin
      n_fail++;
      $display("FAIL serv_mask: mask=%b srv=%b ie=%b required 0000 1 0", mask, in_service, ie);
    end
  endtask

  task automatic test_edge();
    do_reset();
    arm(4'b1111);
    irq = 4'b0100; boundary = 0;
    tick();
    irq = 0;
    tick(); tick();
    boundary = 1;
`ifdef INT_EDGE_EN
    q.push_back('{8'hF2, 4'b0100});
    wait_redirect(got);
    pop_check("edge");
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({stall, redirect} !== 2'b00) begin n_fail++; $display("FAIL level_pulse: stall=%b redir=%b required 0 0", stall, redirect); end
    end
`endif
    boundary = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_gating();
    test_reti();
    test_ck2_reset();
    test_conflicts();
    test_edge();
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL queue_left: size=%0d required 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Interrupt sequencer for the 8-bit pipelined core.
- Arbitrates NREQ interrupt request lines by fixed priority and waits for an instruction boundary.
- Saves the condition flags (cc_c, cc_z) and the return PC, then redirects fetch to a vector.
- Tracks the handler until RETI; the saved flags feed int_c/int_z of the condition-code block for restore.

Parameters:
- NREQ, 4, number of interrupt request lines; index 0 has the highest priority.
- PC_W, 8, program counter width.
- VEC_BASE, 8'hF0, vector address of request 0; request i vectors to VEC_BASE+i (PC_W-bit modulo add).

Ports:
- ck  in  1  clock.
- res  in  1  reset, synchronous, active-high.
- ck2  in  1  phase enable; state, registers and pulse outputs advance only on ck edges with ck2==0.
- irq  in  NREQ  interrupt requests.
- mask_we  in  1  mask register write strobe.
- mask_wdata  in  NREQ  new mask value; 1 = enabled.
- ie_set  in  1  EI instruction: set global enable.
- ie_clr  in  1  DI instruction: clear global enable.
- kind  in  4  decoded instruction class; 4'b1000 = RETI.
- boundary  in  1  instruction boundary; pipeline can accept a redirect.
- pc  in  PC_W  return address at the boundary.
- cc_c  in  1  current carry flag.
- cc_z  in  1  current zero flag.
- int_c  out  1  saved carry flag.
- int_z  out  1  saved zero flag.
- int_pc  out  PC_W  saved return PC.
- stall  out  1  fetch hold.
- redirect  out  1  fetch redirect pulse.
- vec  out  PC_W  redirect target.
- int_ack  out  NREQ  one-hot acknowledge pulse.
- in_service  out  1  handler active.
- ie  out  1  global enable.
- mask  out  NREQ  mask register.

Behaviour:
- Reset: state=IDLE; ie=0, mask=0, int_c=0, int_z=0, int_pc=0, stall=0, redirect=0, vec=0, int_ack=0, in_service=0.
- Reset applies on the next ck edge regardless of ck2, and aborts any state (including SAVE/VECT) with no pulse emitted.
- "Enabled cycle" means a ck edge with ck2==0 and res==0. Nothing below changes on other edges.
- Qualifying set: pend & mask, where pend is defined by the optional feature. Winner = lowest set index; it is captured into an internal idx register.
- IDLE:
  - Go to SAVE if ie==1, the qualifying set is nonzero, boundary==1, and ie_clr==0 (clr in the same cycle blocks entry). idx is captured at this edge.
  - Otherwise stay in IDLE.
- SAVE (one enabled cycle): stall=1.
  - At exit: int_c<=cc_c, int_z<=cc_z, int_pc<=pc, ie<=0; go to VECT.
- VECT (one enabled cycle): stall=1, redirect=1, vec=VEC_BASE+idx, int_ack[idx]=1; go to SERV.
- SERV: in_service=1; stall=0; ie_set/ie_clr ignored (no nesting).
  - On kind==4'b1000: go to IDLE, ie<=1.
  - int_c/int_z/int_pc stay stable through the RETI edge so the CC block restores from them; they hold until the next SAVE.
- Latency: boundary with a qualifying request -> redirect 2 enabled cycles later.
- redirect, int_ack, vec: registered; each is 1 (vec valid) for exactly one enabled cycle, and redirect/int_ack are 0 (vec=0) otherwise.
- ie in IDLE: ie_clr wins over ie_set when both are asserted; the update is visible next cycle.
- mask_we: accepted in any state; the new mask qualifies requests from the next cycle.
- RETI outside SERV: ignored.
- Request deasserting after capture: the sequence completes using the captured idx.

Optional Feature:
- Macro: INT_EDGE_EN.
- Defined:
  - Per-line pending register pend, set on a 0->1 transition of irq[i] (previous value registered on enabled cycles).
  - Cleared on the VECT cycle for idx.
  - A new edge on the same cycle as the clear leaves pend set.
  - Reset clears pend and the edge history.
- Undefined: pend = irq (level-sensitive, no storage). A still-asserted line re-enters after RETI.

Test Plan:
1. Priority: mask=4'b1111, ie=1, irq=4'b0110, boundary=1, pc=8'h3A, cc_c=1, cc_z=0.
   -> stall high for 2 cycles; redirect with vec=8'hF1; int_ack=4'b0010; int_pc=8'h3A, int_c=1, int_z=0; ie=0, in_service=1.
2. Gating: irq=4'b0001 with ie=0, then with mask=0, then with boundary=0 -> no stall/redirect in any case. Then boundary=1 with ie=1, mask=1 -> vec=8'hF0.
3. RETI: in SERV, kind=4'b1000 -> IDLE, ie=1, in_service=0, int_c/int_z unchanged. A kind=4'b1000 in IDLE -> no state change.
4. ck2 gating and reset: hold ck2=1 during SAVE -> state frozen, stall held, no pulse. Assert res in VECT -> next edge, all outputs at reset values and no int_ack.
5. Conflicts: ie_set and ie_clr in the same cycle -> ie=0. ie_clr in the same cycle as a qualifying request -> no entry. mask_we=1 with mask_wdata=0 in SERV -> mask=0.
6. INT_EDGE_EN: irq[2] 1-cycle pulse, then low -> still serviced (vec=8'hF2). Without the macro, the same pulse with boundary=0 -> never serviced.
